load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory access stage sitting directly downstream of the datapath ALU.
//  Consumes the memory request the datapath produces (address = ALU result, store data = rs2).
//  Runs a valid/ready bus transaction to a variable-latency memory.
//  Returns formatted load data for write-back (wb_sel = 2'b10) and holds the PC via stall.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+RESP before the transaction is aborted with bus_error
//  CNT_W           8    timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  req_rd_en    in   1   load request from controller
//  req_wr_en    in   1   store request from controller
//  req_addr     in   32  byte address (ALU result)
//  req_wdata    in   32  store data (rs2)
//  req_funct3   in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  stall        out  1   1 = datapath must hold PC/instruction and suppress reg write
//  load_data    out  32  sign/zero-extended load result; valid in DONE
//  misaligned   out  1   1-cycle pulse: misaligned access, no bus transaction issued
//  bus_error    out  1   1-cycle pulse: timeout abort
//  mem_valid    out  1   bus request valid
//  mem_ready    in   1   bus accepts request when mem_valid & mem_ready
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word-aligned address ({req_addr[31:2],2'b00})
//  mem_wdata    out  32  lane-replicated store data
//  mem_be       out  4   byte enables
//  mem_rvalid   in   1   read data valid
//  mem_rdata    in   32  read data word
// BEHAVIOUR
//  Reset: state=IDLE; timeout counter cleared.
//   All outputs 0 (stall, load_data, misaligned, bus_error, mem_valid, mem_we, mem_addr, mem_wdata, mem_be).
//   Reset asserted mid-transaction abandons it; mem_valid is 0 from the next edge.
//  Request = req_rd_en | req_wr_en. If both are 1, the access is a store.
//  FSM states: IDLE, REQ, RESP, DONE.
//  IDLE:
//   - Request and aligned: stall=1 combinationally in the same cycle.
//     Latch addr/wdata/be/funct3/we; go to REQ.
//   - Request and misaligned (H: addr[0]!=0; W: addr[1:0]!=0): misaligned=1 for this cycle.
//     stall=0, no transaction, stay in IDLE.
//   - No request: stall=0.
//  REQ: mem_valid=1; bus outputs are registered and stable until the handshake. stall=1.
//   - Handshake: store -> DONE; load -> RESP.
//  RESP: stall=1; wait for mem_rvalid. On mem_rvalid, register the formatted mem_rdata into load_data; go to DONE.
//  DONE: stall=0 for exactly one cycle; load_data held; next state IDLE.
//   The datapath advances the PC on this edge.
//  mem_rvalid outside RESP is ignored. mem_ready is ignored unless mem_valid=1.
//  Timeout: the counter increments every cycle in REQ/RESP.
//   On reaching TIMEOUT_CYCLES: bus_error=1 for 1 cycle, load_data=0, mem_valid drops, go to DONE.
//   The counter clears on entering REQ.
//  Store formatting (o = addr[1:0]):
//   - SB: wdata = {4{b}}, be = 4'b0001<<o
//   - SH: wdata = {2{h}}, be = 4'b0011<<o
//   - SW: be = 4'b1111
//   - mem_be = 0 for loads.
//  Load formatting: select the byte/halfword at lane o.
//   - 000/001: sign-extend. 100/101: zero-extend. 010: full word.
//   - 011/110/111: treated as 010.
//  Minimum latency, zero-wait memory: load = 4 cycles (IDLE, REQ, RESP, DONE); store = 3 cycles.
// TESTING
//  1. SW addr=0x100 data=0xDEADBEEF, mem_ready=1 -> mem_be=1111, mem_addr=0x100; stall high 2 cycles, then DONE.
//  2. LB addr=0x103, mem_rdata=0x80000000, rvalid after 3 cycles -> load_data=0xFFFFFF80; LBU -> 0x00000080.
//  3. SH addr=0x202 data=0x0000ABCD -> mem_wdata=0xABCDABCD, mem_be=1100; LW addr=0x102 -> misaligned pulse, mem_valid stays 0.
//  4. mem_ready held 0 for 255 cycles -> bus_error pulse, load_data=0, stall falls in DONE.
//  5. Reset asserted during RESP -> next cycle state IDLE, all outputs 0; stray mem_rvalid ignored.
//  6. req_rd_en=req_wr_en=1 -> store performed (mem_we=1); mem_ready delayed 5 cycles -> mem_addr/wdata/be stable throughout.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns a datapath memory request into a valid/ready bus
// transaction, formats store lanes and load results, and stalls the datapath
// until the access completes, aborts, or turns out to be misaligned.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic        r_mem_valid;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_load_data;
  logic        r_bus_error;

  logic        w_req;
  logic        w_misal;
  logic        w_busy;
  logic        w_handshake;
  logic        w_timeout;
  logic        w_accept;
  logic        w_abort;
  logic        w_stall;
  logic        w_misaligned;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_be;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_ld_fmt;

  // A simultaneous read and write enable is treated as a store.
  assign w_req       = req_rd_en | req_wr_en;
  assign w_busy      = (r_state == S_REQ) || (r_state == S_RESP);
  assign w_handshake = r_mem_valid & mem_ready;
  assign w_cnt_next  = r_cnt + 1'b1;
  assign w_timeout   = w_busy && (w_cnt_next == TIMEOUT_VAL);

  // Alignment check on the incoming request: halfwords need addr[0]=0, words addr[1:0]=0.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_misal = 1'b0;
    case (req_funct3[1:0])
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = req_addr[0];
      default: w_misal = |req_addr[1:0];
    endcase
  end

  // Store lane replication and byte enables; loads drive no enables.
  always_comb begin
    w_st_wdata = req_wdata;
    w_st_be    = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{req_wdata[7:0]}};
        w_st_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{req_wdata[15:0]}};
        w_st_be    = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
    if (!req_wr_en) begin
      w_st_wdata = 32'h0;
      w_st_be    = 4'b0000;
    end
  end

  // Load result extraction: pick the addressed lane, then sign/zero-extend.
  always_comb begin
    w_lane_byte = mem_rdata[7:0];
    case (r_off)
      2'd1:    w_lane_byte = mem_rdata[15:8];
      2'd2:    w_lane_byte = mem_rdata[23:16];
      2'd3:    w_lane_byte = mem_rdata[31:24];
      default: ;
    endcase
    w_lane_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_fmt = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b001:  w_ld_fmt = {{16{w_lane_half[15]}}, w_lane_half};
      3'b100:  w_ld_fmt = {24'h0, w_lane_byte};
      3'b101:  w_ld_fmt = {16'h0, w_lane_half};
      default: w_ld_fmt = mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state and combinational stall/misaligned/accept/abort decode.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_misaligned = 1'b0;
    w_accept     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_misal) begin
            w_misaligned = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_accept     = 1'b1;
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (w_handshake) begin
          w_state_next = r_mem_we ? S_DONE : S_RESP;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_RESP: begin
        w_stall = 1'b1;
        if (mem_rvalid) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Timeout counter: cleared when a request is accepted, counts while in REQ/RESP.
  always_ff @(posedge clk) begin
    if (reset)         r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_busy)   r_cnt <= w_cnt_next;
  end

  // Bus request registers, latched request attributes, load result and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'b0000;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_load_data <= 32'h0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= w_abort;
      if (w_accept) begin
        r_mem_valid <= 1'b1;
        r_mem_we    <= req_wr_en;
        r_mem_addr  <= {req_addr[31:2], 2'b00};
        r_mem_wdata <= w_st_wdata;
        r_mem_be    <= w_st_be;
        r_funct3    <= req_funct3;
        r_off       <= req_addr[1:0];
      end else if (w_handshake || w_abort) begin
        r_mem_valid <= 1'b0;
      end
      if (w_abort) begin
        r_load_data <= 32'h0;
      end else if ((r_state == S_RESP) && mem_rvalid) begin
        r_load_data <= w_ld_fmt;
      end
    end
  end

  // Combinational handshake outputs are forced low while reset is asserted.
  assign stall      = w_stall & ~reset;
  assign misaligned = w_misaligned & ~reset;
  assign bus_error  = r_bus_error;
  assign load_data  = r_load_data;
  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, load formatting, misalignment,
// timeout abort, reset mid-transaction and dual-enable store with a slow bus.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_rd_en;
  logic        req_wr_en;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_rd_en  (req_rd_en),
    .req_wr_en  (req_wr_en),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .stall      (stall),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_rd_en  = 1'b0;
    req_wr_en  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    clear_req();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({stall, misaligned, bus_error, mem_valid, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {stall, misaligned, bus_error, mem_valid, mem_we});
    end
    checks++;
    if ({load_data, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: got ld=%h addr=%h wd=%h be=%b expected all zero", load_data, mem_addr, mem_wdata, mem_be);
    end
  endtask

  // One zero-wait store: IDLE (stall) -> REQ (bus fields) -> DONE (stall low).
  task automatic run_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                           input logic [31:0] exp_wd, input logic [3:0] exp_be, input string name);
    req_wr_en = 1'b1; req_addr = addr; req_wdata = wd; req_funct3 = f3; mem_ready = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL %s_idle_stall: got %b expected 1", name, stall); end
    tick();
    clear_req();
    #1;
    checks++;
    if ({mem_valid, mem_we, stall} !== 3'b111) begin
      errors++; $display("FAIL %s_req_ctrl: got valid/we/stall=%b expected 111", name, {mem_valid, mem_we, stall});
    end
    checks++;
    if (mem_addr !== {addr[31:2], 2'b00} || mem_wdata !== exp_wd || mem_be !== exp_be) begin
      errors++;
      $display("FAIL %s_req_bus: got addr=%h wd=%h be=%b expected addr=%h wd=%h be=%b",
               name, mem_addr, mem_wdata, mem_be, {addr[31:2], 2'b00}, exp_wd, exp_be);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL %s_done: got stall=%b valid=%b expected 0 0", name, stall, mem_valid);
    end
    mem_ready = 1'b0;
    tick();
  endtask

  // One load: rvalid arrives in the dly-th RESP cycle; checks result in DONE and after.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rd,
                          input int dly, input logic [31:0] exp, input string name);
    int bad;
    req_rd_en = 1'b1; req_addr = addr; req_funct3 = f3; mem_ready = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL %s_idle_stall: got %b expected 1", name, stall); end
    tick();
    clear_req();
    #1;
    checks++;
    if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== {addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s_req_bus: got valid=%b we=%b be=%b addr=%h expected 1 0 0000 %h",
               name, mem_valid, mem_we, mem_be, mem_addr, {addr[31:2], 2'b00});
    end
    tick();
    mem_ready = 1'b0;
    bad = 0;
    for (int i = 1; i < dly; i++) begin
      if (stall !== 1'b1 || mem_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_resp_wait: got %0d bad cycles expected 0", name, bad); end
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if (load_data !== exp || stall !== 1'b0) begin
      errors++; $display("FAIL %s_done: got ld=%h stall=%b expected ld=%h stall=0", name, load_data, stall, exp);
    end
    tick();
    checks++;
    if (load_data !== exp) begin errors++; $display("FAIL %s_hold: got %h expected %h", name, load_data, exp); end
  endtask

  task automatic test_store();
    run_store(32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, "sw");
    run_store(32'h0000_0202, 3'b001, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b1100, "sh");
    run_store(32'h0000_0301, 3'b000, 32'h1234_5678, 32'h7878_7878, 4'b0010, "sb");
  endtask

  task automatic test_load_format();
    run_load(32'h0000_0103, 3'b000, 32'h8000_0000, 3, 32'hFFFF_FF80, "lb");
    run_load(32'h0000_0103, 3'b100, 32'h8000_0000, 3, 32'h0000_0080, "lbu");
    run_load(32'h0000_0102, 3'b001, 32'h8001_1234, 1, 32'hFFFF_8001, "lh");
    run_load(32'h0000_0102, 3'b101, 32'h8001_1234, 2, 32'h0000_8001, "lhu");
    run_load(32'h0000_0104, 3'b110, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, "lw_f3_110");
  endtask

  task automatic test_misaligned();
    req_rd_en = 1'b1; req_addr = 32'h0000_0102; req_funct3 = 3'b010; mem_ready = 1'b1;
    #1;
    checks++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL lw_misal: got misal=%b stall=%b expected 1 0", misaligned, stall);
    end
    tick();
    clear_req();
    #1;
    checks++;
    if (mem_valid !== 1'b0 || misaligned !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL lw_misal_after: got valid=%b misal=%b stall=%b expected 000", mem_valid, misaligned, stall);
    end
    req_wr_en = 1'b1; req_addr = 32'h0000_0203; req_funct3 = 3'b001;
    #1;
    checks++;
    if (misaligned !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL sh_misal: got misal=%b stall=%b expected 1 0", misaligned, stall);
    end
    tick();
    clear_req();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL sh_misal_valid: got %b expected 0", mem_valid); end
  endtask

  task automatic test_timeout();
    int bad;
    req_rd_en = 1'b1; req_addr = 32'h0000_0400; req_funct3 = 3'b010; mem_ready = 1'b0;
    tick();
    clear_req();
    #1;
    bad = 0;
    for (int i = 1; i < 255; i++) begin
      if (mem_valid !== 1'b1 || stall !== 1'b1 || bus_error !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL to_wait: got %0d bad cycles valid=%b expected 0 1", bad, mem_valid);
    end
    tick();
    checks++;
    if (bus_error !== 1'b1 || load_data !== 32'h0 || stall !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_abort: got berr=%b ld=%h stall=%b valid=%b expected 1 0 0 0", bus_error, load_data, stall, mem_valid);
    end
    tick();
    checks++;
    if (bus_error !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b expected 0", bus_error); end
  endtask

  task automatic test_reset_mid();
    run_load(32'h0000_0101, 3'b000, 32'h0000_7F00, 1, 32'h0000_007F, "lb_pos");
    req_rd_en = 1'b1; req_addr = 32'h0000_0500; req_funct3 = 3'b010; mem_ready = 1'b1;
    tick();
    clear_req();
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL rst_resp_stall: got %b expected 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({stall, misaligned, bus_error, mem_valid, mem_we} !== 5'b0 ||
        {load_data, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
      errors++;
      $display("FAIL rst_mid: got ctrl=%b ld=%h addr=%h wd=%h be=%b expected all zero",
               {stall, misaligned, bus_error, mem_valid, mem_we}, load_data, mem_addr, mem_wdata, mem_be);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if (load_data !== 32'h0 || stall !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL stray_rvalid: got ld=%h stall=%b valid=%b expected 0 0 0", load_data, stall, mem_valid);
    end
  endtask

  task automatic test_both_enables();
    int bad;
    req_rd_en = 1'b1; req_wr_en = 1'b1; req_addr = 32'h0000_0600;
    req_wdata = 32'h1357_9BDF; req_funct3 = 3'b010; mem_ready = 1'b0;
    tick();
    clear_req();
    #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_0600 ||
          mem_wdata !== 32'h1357_9BDF || mem_be !== 4'b1111 || stall !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL both_stable: got %0d unstable cycles expected 0", bad); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL both_we: got we=%b valid=%b expected 1 1", mem_we, mem_valid);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL both_done: got stall=%b valid=%b expected 0 0", stall, mem_valid);
    end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    run_store(32'h0000_0700, 3'b000, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b0001, "b2b_sb");
    run_load(32'h0000_0706, 3'b001, 32'h7FFF_0000, 1, 32'h0000_7FFF, "b2b_lh");
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a stuck simulator.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store();
    test_load_format();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_both_enables();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
